saes_enc_ctrl: RTL and testbench

SAES_ENC_CTRL -- requirements
Module: saes_enc_ctrl

---
 rtl/saes_pkg.sv | 45 ++++
 rtl/saes_enc_ctrl_if.sv | 23 ++
 rtl/saes_subnib4.sv | 13 +
 rtl/saes_enc_ctrl.sv | 158 +++++++++++++++
 tb/tb_saes_enc_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/saes_pkg.sv
// rtl/saes_pkg.sv - shared S-AES state codes, S-box table, round constants and nibble helpers
package saes_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_KEY1 = 3'd1;
  localparam state_t ST_RND1 = 3'd2;
  localparam state_t ST_KEY2 = 3'd3;
  localparam state_t ST_RND2 = 3'd4;
  localparam state_t ST_DONE = 3'd5;

  // entry for nibble 0 sits in the top four bits
  localparam logic [63:0] SBOX_TABLE = 64'h94AB_D185_6203_CEF7;

  localparam logic [7:0] RCON1 = 8'h80;
  localparam logic [7:0] RCON2 = 8'h30;

  function automatic logic [3:0] sbox(input logic [3:0] n);
    logic [5:0] idx;
    idx = {~n, 2'b00};
    return SBOX_TABLE[idx +: 4];
  endfunction

  // x^2 * a in GF(2^4) modulo x^4 + x + 1
  function automatic logic [3:0] gf_mul4(input logic [3:0] a);
    logic [3:0] x2;
    x2 = {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    return {x2[2:0], 1'b0} ^ (x2[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [7:0] rot_nib(input logic [7:0] w);
    return {w[3:0], w[7:4]};
  endfunction

  function automatic logic [15:0] shift_row(input logic [15:0] s);
    return {s[15:12], s[3:0], s[7:4], s[11:8]};
  endfunction

  function automatic logic [15:0] mix_col(input logic [15:0] s);
    return {s[15:12] ^ gf_mul4(s[11:8]), gf_mul4(s[15:12]) ^ s[11:8],
            s[7:4] ^ gf_mul4(s[3:0]),    gf_mul4(s[7:4]) ^ s[3:0]};
  endfunction

endpackage

// File: rtl/saes_enc_ctrl_if.sv
// rtl/saes_enc_ctrl_if.sv - request/response handshake bundle of the S-AES encryption controller
interface saes_enc_ctrl_if;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_key;
  logic [15:0] in_pt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_ct;
  logic        busy;

  modport slave (
    input  in_valid, in_key, in_pt, out_ready,
    output in_ready, out_valid, out_ct, busy
  );

  modport master (
    output in_valid, in_key, in_pt, out_ready,
    input  in_ready, out_valid, out_ct, busy
  );

endinterface

// File: rtl/saes_subnib4.sv
// rtl/saes_subnib4.sv - four parallel S-AES S-box lookups on a 16-bit word
module saes_subnib4
  import saes_pkg::*;
(
  input  logic [15:0] in_data,
  output logic [15:0] out_data
);

  for (genvar i = 0; i < 4; i++) begin : g_nib
    assign out_data[4*i +: 4] = sbox(in_data[4*i +: 4]);
  end

endmodule

// File: rtl/saes_enc_ctrl.sv
// rtl/saes_enc_ctrl.sv - sequential S-AES encryptor, one block in flight, shared S-box layer
// Build option SAES_KEY_CACHE_EN: reuse the last expanded schedule when the key repeats.
module saes_enc_ctrl
  import saes_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  saes_enc_ctrl_if.slave bus
);

  state_t      state_q, state_d;
  logic [15:0] data_q, data_d;
  logic [15:0] w01_q, w01_d;
  logic [15:0] k1_q, k1_d;
  logic [15:0] k2_q, k2_d;
  logic        rdy_en_q, rdy_en_d;
  logic        in_ready, hs;
  logic [15:0] sb_in, sb_out;
  logic [7:0]  key_sub, w2, w4;
`ifdef SAES_KEY_CACHE_EN
  logic [15:0] cache_key_q, cache_key_d;
  logic [15:0] cache_k1_q, cache_k1_d;
  logic [15:0] cache_k2_q, cache_k2_d;
  logic        cache_vld_q, cache_vld_d;
  logic        skip_q, skip_d;
  logic        cache_hit;
`endif

  // in_ready stays low until the first edge after reset release
  assign rdy_en_d      = 1'b1;
  assign in_ready      = rdy_en_q & (state_q == ST_IDLE);
  assign hs            = bus.in_valid & in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_ct    = (state_q == ST_DONE) ? data_q : 16'h0000;
  assign bus.busy      = (state_q != ST_IDLE);

  // key states need only two S-box nibbles; they ride in the upper byte of the layer
  always_comb begin
    sb_in = data_q;
    if (state_q == ST_KEY1) begin
      sb_in = {rot_nib(w01_q[7:0]), 8'h00};
    end else if (state_q == ST_KEY2) begin
      sb_in = {rot_nib(k1_q[7:0]), 8'h00};
    end
  end

  saes_subnib4 u_subnib (
    .in_data  (sb_in),
    .out_data (sb_out)
  );

  assign key_sub = sb_out[15:8];
  assign w2      = w01_q[15:8] ^ RCON1 ^ key_sub;
  assign w4      = k1_q[15:8] ^ RCON2 ^ key_sub;

`ifdef SAES_KEY_CACHE_EN
  assign cache_hit = cache_vld_q & (bus.in_key == cache_key_q);
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    w01_d   = w01_q;
    k1_d    = k1_q;
    k2_d    = k2_q;
`ifdef SAES_KEY_CACHE_EN
    cache_key_d = cache_key_q;
    cache_k1_d  = cache_k1_q;
    cache_k2_d  = cache_k2_q;
    cache_vld_d = cache_vld_q;
    skip_d      = skip_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          data_d  = bus.in_pt ^ bus.in_key;
          w01_d   = bus.in_key;
          state_d = ST_KEY1;
`ifdef SAES_KEY_CACHE_EN
          skip_d = cache_hit;
          if (cache_hit) begin
            k1_d    = cache_k1_q;
            k2_d    = cache_k2_q;
            state_d = ST_RND1;
          end
`endif
        end
      end
      ST_KEY1: begin
        k1_d    = {w2, w2 ^ w01_q[7:0]};
        state_d = ST_RND1;
      end
      ST_RND1: begin
        data_d  = mix_col(shift_row(sb_out)) ^ k1_q;
        state_d = ST_KEY2;
`ifdef SAES_KEY_CACHE_EN
        if (skip_q) state_d = ST_RND2;
`endif
      end
      ST_KEY2: begin
        k2_d    = {w4, w4 ^ k1_q[7:0]};
        state_d = ST_RND2;
`ifdef SAES_KEY_CACHE_EN
        cache_key_d = w01_q;
        cache_k1_d  = k1_q;
        cache_k2_d  = {w4, w4 ^ k1_q[7:0]};
        cache_vld_d = 1'b1;
`endif
      end
      ST_RND2: begin
        data_d  = shift_row(sb_out) ^ k2_q;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      data_q   <= 16'h0000;
      w01_q    <= 16'h0000;
      k1_q     <= 16'h0000;
      k2_q     <= 16'h0000;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      w01_q    <= w01_d;
      k1_q     <= k1_d;
      k2_q     <= k2_d;
      rdy_en_q <= rdy_en_d;
    end
  end

`ifdef SAES_KEY_CACHE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_key_q <= 16'h0000;
      cache_k1_q  <= 16'h0000;
      cache_k2_q  <= 16'h0000;
      cache_vld_q <= 1'b0;
      skip_q      <= 1'b0;
    end else begin
      cache_key_q <= cache_key_d;
      cache_k1_q  <= cache_k1_d;
      cache_k2_q  <= cache_k2_d;
      cache_vld_q <= cache_vld_d;
      skip_q      <= skip_d;
    end
  end
`endif

endmodule

// File: tb/tb_saes_enc_ctrl.sv
// tb/tb_saes_enc_ctrl.sv - self-checking bench for saes_enc_ctrl against a software S-AES model
module tb_saes_enc_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic        cache_vld_m = 1'b0;
  logic [15:0] cache_key_m = 16'h0000;
  logic [15:0] model_q[$];

  localparam logic [3:0] SB_M [16] = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
                                       4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};

  saes_enc_ctrl_if bus ();

  saes_enc_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (8'(a) << i);
    for (int i = 7; i >= 4; i--) if (p[i]) p = p ^ (8'h13 << (i - 4));
    return p[3:0];
  endfunction

  function automatic logic [7:0] g_fn(input logic [7:0] w, input logic [7:0] rc);
    return rc ^ {SB_M[w[3:0]], SB_M[w[7:4]]};
  endfunction

  function automatic logic [15:0] saes_model(input logic [15:0] key, input logic [15:0] pt);
    logic [7:0]  w0, w1, w2, w3, w4, w5;
    logic [3:0]  st [2][2];
    logic [3:0]  a, b, t;
    logic [15:0] s;
    w0 = key[15:8];
    w1 = key[7:0];
    w2 = w0 ^ g_fn(w1, 8'h80);
    w3 = w2 ^ w1;
    w4 = w2 ^ g_fn(w3, 8'h30);
    w5 = w4 ^ w3;
    s = pt ^ key;
    for (int r = 1; r <= 2; r++) begin
      st[0][0] = SB_M[s[15:12]];
      st[1][0] = SB_M[s[11:8]];
      st[0][1] = SB_M[s[7:4]];
      st[1][1] = SB_M[s[3:0]];
      t = st[1][0];
      st[1][0] = st[1][1];
      st[1][1] = t;
      if (r == 1) begin
        for (int c = 0; c < 2; c++) begin
          a = st[0][c];
          b = st[1][c];
          st[0][c] = a ^ gf_mul(4'h4, b);
          st[1][c] = gf_mul(4'h4, a) ^ b;
        end
      end
      s = {st[0][0], st[1][0], st[0][1], st[1][1]} ^ ((r == 1) ? {w2, w3} : {w4, w5});
    end
    return s;
  endfunction

  function automatic int exp_lat(input logic [15:0] key);
`ifdef SAES_KEY_CACHE_EN
    return (cache_vld_m && key == cache_key_m) ? 3 : 5;
`else
    return 5;
`endif
  endfunction

  // issues one request, scrambles the inputs after acceptance and returns cycles until out_valid
  task automatic start_block(input logic [15:0] key, input logic [15:0] pt, output int lat);
    int n;
    bus.in_valid = 1'b1;
    bus.in_key = key;
    bus.in_pt = pt;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      bus.in_valid = 1'b0;
      lat = -1;
      return;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_key = 16'($urandom);
    bus.in_pt = 16'($urandom);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (bus.out_valid !== 1'b1) begin
      lat = -1;
      return;
    end
    if (!(cache_vld_m && key == cache_key_m)) begin
      cache_vld_m = 1'b1;
      cache_key_m = key;
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_key = 16'h0000;
    bus.in_pt = 16'h0000;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    cache_vld_m = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_checks++;
    if (bus.out_ct !== 16'h0000) begin n_fail++; $display("FAIL reset_out_ct got %h want 0000", bus.out_ct); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL release_in_ready got %b want 0", bus.in_ready); end
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL first_edge_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_vector();
    int lat;
    int el;
    el = exp_lat(16'hA73B);
    bus.out_ready = 1'b1;
    start_block(16'hA73B, 16'h6F6B, lat);
    n_checks++;
    if (lat !== el) begin n_fail++; $display("FAIL vector_latency got %0d want %0d", lat, el); end
    n_checks++;
    if (bus.out_ct !== 16'h0738) begin n_fail++; $display("FAIL vector_ct got %h want 0738", bus.out_ct); end
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL vector_busy got %b want 1", bus.busy); end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_ct !== 16'h0000) begin
      n_fail++; $display("FAIL vector_after got valid %b ct %h want 0 0000", bus.out_valid, bus.out_ct);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL vector_idle_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_stall();
    int lat;
    int el;
    el = exp_lat(16'hA73B);
    bus.out_ready = 1'b0;
    start_block(16'hA73B, 16'h6F6B, lat);
    n_checks++;
    if (lat !== el) begin n_fail++; $display("FAIL stall_latency got %0d want %0d", lat, el); end
    bus.in_valid = 1'b1;
    bus.in_key = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_ct !== 16'h0738 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d got valid %b ct %h ready %b want 1 0738 0",
                 i, bus.out_valid, bus.out_ct, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release got valid %b want 0", bus.out_valid); end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_single got valid %b want 0", bus.out_valid); end
  endtask

  task automatic test_mid_reset();
    int lat;
    int n;
    int seen;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_key = 16'hA73B;
    bus.in_pt = 16'h6F6B;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    cache_vld_m = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_ct !== 16'h0000) begin
      n_fail++;
      $display("FAIL midreset_outputs got busy %b valid %b ready %b ct %h want 0 0 0 0000",
               bus.busy, bus.out_valid, bus.in_ready, bus.out_ct);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL midreset_no_output got %0d valid cycles want 0", seen); end
    start_block(16'hA73B, 16'h6F6B, lat);
    n_checks++;
    if (lat !== 5) begin n_fail++; $display("FAIL midreset_latency got %0d want 5", lat); end
    n_checks++;
    if (bus.out_ct !== 16'h0738) begin n_fail++; $display("FAIL midreset_ct got %h want 0738", bus.out_ct); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [15:0] key3;
    logic [15:0] pt3;
    int want [3];
`ifdef SAES_KEY_CACHE_EN
    want = '{5, 3, 5};
`else
    want = '{5, 5, 5};
`endif
    rst_n = 1'b0;
    cache_vld_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b1;
    key3 = 16'hA73B ^ 16'($urandom_range(1, 65535));
    pt3 = 16'($urandom);
    for (int b = 0; b < 3; b++) begin
      if (b > 0) begin
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_done_ready blk %0d got %b want 0", b, bus.in_ready); end
      end
      start_block((b < 2) ? 16'hA73B : key3, (b < 2) ? 16'h6F6B : pt3, lat);
      n_checks++;
      if (lat !== want[b]) begin n_fail++; $display("FAIL b2b_latency blk %0d got %0d want %0d", b, lat, want[b]); end
      n_checks++;
      if (bus.out_ct !== ((b < 2) ? 16'h0738 : saes_model(key3, pt3))) begin
        n_fail++;
        $display("FAIL b2b_ct blk %0d got %h want %h", b, bus.out_ct, (b < 2) ? 16'h0738 : saes_model(key3, pt3));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat;
    int el;
    int stalls;
    int n_xfer;
    logic [15:0] key;
    logic [15:0] pt;
    logic [15:0] prev_key;
    logic [15:0] exp_ct;
    n_xfer = 0;
    prev_key = 16'hA73B;
    for (int i = 0; i < 1000; i++) begin
      key = ($urandom_range(0, 3) == 0) ? prev_key : 16'($urandom);
      pt = 16'($urandom);
      prev_key = key;
      el = exp_lat(key);
      model_q.push_back(saes_model(key, pt));
      bus.out_ready = 1'($urandom_range(0, 1));
      start_block(key, pt, lat);
      n_checks++;
      if (lat !== el) begin
        n_fail++;
        $display("FAIL rand_latency blk %0d got %0d want %0d", i, lat, el);
        if (lat < 0) break;
      end
      exp_ct = model_q.pop_front();
      n_checks++;
      if (bus.out_ct !== exp_ct) begin n_fail++; $display("FAIL rand_ct blk %0d got %h want %h", i, bus.out_ct, exp_ct); end
      if (bus.out_ready !== 1'b1) begin
        stalls = $urandom_range(0, 3);
        repeat (stalls) begin
          @(negedge clk);
          n_checks++;
          if (bus.out_valid !== 1'b1 || bus.out_ct !== exp_ct) begin
            n_fail++;
            $display("FAIL rand_stall blk %0d got valid %b ct %h want 1 %h", i, bus.out_valid, bus.out_ct, exp_ct);
          end
        end
        bus.out_ready = 1'b1;
      end
      @(negedge clk);
      n_xfer++;
      n_checks++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_dup blk %0d got valid %b want 0", i, bus.out_valid); end
    end
    bus.out_ready = 1'b0;
    n_checks++;
    if (n_xfer !== 1000 || model_q.size() !== 0) begin
      n_fail++;
      $display("FAIL rand_count got %0d transfers %0d pending want 1000 0", n_xfer, model_q.size());
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vector();
    test_stall();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
